// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: program-memory read port plus the decoder-side
// valid/ready instruction stream. The fetch unit is the master of both.
interface instruction_fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_addr;
  logic               instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_data, instr_addr,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_data, instr_addr,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one-outstanding-request reader of program memory
// feeding a small prefetch FIFO that the decoder drains with valid/ready.
// A redirect flushes the FIFO and restarts fetching at redirect_addr; a
// response still in flight at that moment is discarded when it returns.
// Optional feature macro IFETCH_STATS_EN adds stat_discards, a saturating
// count of responses dropped because of a redirect.
module instruction_fetch #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_addr,
  instruction_fetch_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [7:0]      stat_discards
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic [PC_W-1:0]    fetch_addr;

  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]    addr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               head_valid;
  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   count_after_pop;
  logic               can_issue;

  assign head_valid      = (count != '0);
  assign pop             = head_valid && bus.instr_ready;
  // A response is kept only if it lands in WAIT with no redirect beside it.
  assign push            = (state == WAIT) && bus.mem_ack && !redirect;
  // Gate issue on occupancy after this cycle's pop so the FIFO cannot overflow.
  assign count_after_pop = count - CNT_W'(pop);
  assign can_issue       = count_after_pop < CNT_W'(DEPTH);

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_addr;
  assign bus.instr_valid = head_valid;
  // Head outputs read as zero while the FIFO is empty (including in reset).
  assign bus.instr_data  = head_valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_addr  = head_valid ? addr_mem[rd_ptr] : '0;

  // Request FSM: issue, wait for ack (or discard it after a redirect), track PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!redirect && can_issue) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (redirect)
        fetch_addr <= redirect_addr;
      else if (push)
        fetch_addr <= fetch_addr + PC_W'(1);
    end
  end

  // FIFO control: pointers and occupancy; redirect flushes ahead of push/pop.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: written on accepted responses only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.mem_rdata;
      addr_mem[wr_ptr] <= mem_addr;
    end
  end

`ifdef IFETCH_STATS_EN
  logic drop;
  assign drop = bus.mem_ack && ((state == DISCARD) || ((state == WAIT) && redirect));

  // Saturating count of responses thrown away because of a redirect.
  always_ff @(posedge clk) begin
    if (reset)
      stat_discards <= 8'h00;
    else if (drop && (stat_discards != 8'hFF))
      stat_discards <= stat_discards + 8'h01;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized
// phase, all checked against a queue-based reference model of the fetch
// stream. Memory returns addr ^ 0xA5 after a random number of wait cycles.
module tb_instruction_fetch;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [PC_W-1:0]    addr;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect;
  logic [PC_W-1:0] redirect_addr;
`ifdef IFETCH_STATS_EN
  logic [7:0]      stat_discards;
`endif

  instruction_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instruction_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .bus           (bus)
`ifdef IFETCH_STATS_EN
    ,
    .stat_discards (stat_discards)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t            q[$];
  logic [PC_W-1:0] model_pc;
  bit              pend;
  bit              disc;
  logic [PC_W-1:0] req_addr;
  int              mwait;
  int              ndisc;
  int              npush;
  int              idle_run;
  bit              prev_redir;
  logic [PC_W-1:0] seen_addr[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit rdy, input bit redir, input logic [PC_W-1:0] raddr,
                      input int wmin, input int wmax, input bit spur);
    bit   ack;
    bit   pop;
    ent_t e;
    if (bus.mem_req && !pend) begin
      chk("issue_addr", bus.mem_addr, model_pc);
      chk("issue_gate", q.size() < DEPTH, 1);
      pend     = 1'b1;
      disc     = 1'b0;
      req_addr = bus.mem_addr;
      mwait    = $urandom_range(wmax, wmin);
    end else if (pend) begin
      chk("req_held", bus.mem_req, 1);
      chk("addr_held", bus.mem_addr, req_addr);
    end
    chk("instr_valid", bus.instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr_data", bus.instr_data, q[0].data);
      chk("instr_addr", bus.instr_addr, q[0].addr);
    end
`ifdef IFETCH_STATS_EN
    chk("stat_discards", stat_discards, (ndisc > 255) ? 255 : ndisc);
`endif
    if (!pend && !bus.mem_req && (q.size() < DEPTH) && !prev_redir) idle_run++;
    else idle_run = 0;
    chk("no_stall", idle_run < 2, 1);
    if (bus.instr_valid && rdy && !redir) seen_addr.push_back(bus.instr_addr);

    if (pend) begin
      if (mwait == 0) ack = 1'b1;
      else begin
        ack = 1'b0;
        mwait--;
      end
    end else begin
      ack = spur;
    end
    bus.mem_ack     = ack;
    bus.mem_rdata   = (pend && ack) ? (req_addr ^ 8'hA5) : 8'($urandom);
    bus.instr_ready = rdy;
    redirect        = redir;
    redirect_addr   = raddr;

    pop = (q.size() != 0) && rdy;
    if (redir) begin
      q.delete();
      model_pc = raddr;
      if (pend && ack) begin
        pend = 1'b0;
        disc = 1'b0;
        ndisc++;
      end else if (pend) begin
        disc = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (pend && ack) begin
        if (disc) ndisc++;
        else begin
          e.data = req_addr ^ 8'hA5;
          e.addr = req_addr;
          q.push_back(e);
          model_pc = model_pc + 8'd1;
          npush++;
        end
        pend = 1'b0;
        disc = 1'b0;
      end
    end
    prev_redir = redir;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset with random inputs and check the reset state; optionally a late ack on release.
  task automatic do_reset(input int n, input bit late_ack);
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (n) begin
      redirect      = 1'($urandom);
      redirect_addr = 8'($urandom);
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instr_data", bus.instr_data, 0);
      chk("rst_instr_addr", bus.instr_addr, 0);
`ifdef IFETCH_STATS_EN
      chk("rst_stat", stat_discards, 0);
`endif
    end
    reset         = 1'b0;
    redirect      = 1'b0;
    bus.mem_ack   = late_ack;
    bus.mem_rdata = 8'($urandom);
    q.delete();
    model_pc   = '0;
    pend       = 1'b0;
    disc       = 1'b0;
    ndisc      = 0;
    idle_run   = 0;
    prev_redir = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    int np0;
    int guard;
    bit seen;
    reset = 1'b1;
    redirect = 1'b0;
    redirect_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.instr_ready = 1'b0;
    npush = 0;
    @(negedge clk);

    // Reset state, then zero-wait streaming at one instruction per 2 cycles.
    do_reset(3, 1'b0);
    np0 = npush;
    seen_addr.delete();
    repeat (20) step(1'b1, 1'b0, '0, 0, 0, 1'b0);
    chk("throughput", npush - np0, 10);
    chk("stream_first_addr", seen_addr.size() > 0 ? seen_addr[0] : 8'hxx, 8'h00);

    // Back-pressure: exactly DEPTH pushes, then fetch resumes at 0x02.
    do_reset(2, 1'b0);
    np0 = npush;
    repeat (10) step(1'b0, 1'b0, '0, 0, 0, 1'b0);
    chk("bp_pushes", npush - np0, 2);
    chk("bp_req_idle", bus.mem_req, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b1, 1'b0, '0, 0, 0, 1'b0);
      if (bus.mem_req && !pend) seen = 1'b1;
    end
    chk("bp_resume_seen", seen, 1);
    chk("bp_resume_addr", bus.mem_addr, 8'h02);

    // Redirect while waiting on a slow response: response dropped, refetch at 0x40.
    do_reset(2, 1'b0);
    step(1'b1, 1'b0, '0, 3, 3, 1'b0);
    step(1'b1, 1'b1, 8'h40, 3, 3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1'b1, 1'b0, '0, 0, 0, 1'b0);
      if (bus.mem_req && !pend) seen = 1'b1;
    end
    chk("wait_redir_seen", seen, 1);
    chk("wait_redir_addr", bus.mem_addr, 8'h40);
`ifdef IFETCH_STATS_EN
    chk("wait_redir_stat", stat_discards, 1);
`endif

    // Redirect coincident with the ack: no DISCARD cycle, next request at 0x80.
    step(1'b1, 1'b1, 8'h80, 0, 0, 1'b0);
    chk("coinc_req_drop", bus.mem_req, 0);
    step(1'b1, 1'b0, '0, 0, 0, 1'b0);
    chk("coinc_next_req", bus.mem_req, 1);
    chk("coinc_next_addr", bus.mem_addr, 8'h80);

    // Address wrap: redirect to 0xFE and stream across 0xFF -> 0x00.
    step(1'b1, 1'b1, 8'hFE, 0, 0, 1'b0);
    seen_addr.delete();
    guard = 0;
    while (seen_addr.size() < 4 && guard < 40) begin
      step(1'b1, 1'b0, '0, 0, 0, 1'b0);
      guard++;
    end
    chk("wrap_count", seen_addr.size() >= 4, 1);
    if (seen_addr.size() >= 4) begin
      chk("wrap_0", seen_addr[0], 8'hFE);
      chk("wrap_1", seen_addr[1], 8'hFF);
      chk("wrap_2", seen_addr[2], 8'h00);
      chk("wrap_3", seen_addr[3], 8'h01);
    end

    // Reset during WAIT with a late ack on release: ack ignored, first fetch at 0x00.
    guard = 0;
    while (!(bus.mem_req && !pend) && guard < 10) begin
      step(1'b1, 1'b0, '0, 0, 0, 1'b0);
      guard++;
    end
    step(1'b1, 1'b0, '0, 5, 5, 1'b0);
    do_reset(3, 1'b1);
    chk("late_ack_req", bus.mem_req, 1);
    chk("late_ack_addr", bus.mem_addr, 8'h00);
    seen_addr.delete();
    repeat (6) step(1'b1, 1'b0, '0, 0, 0, 1'b0);
    chk("late_ack_first", seen_addr.size() > 0 ? seen_addr[0] : 8'hxx, 8'h00);

    // Randomized traffic: back-pressure, variable latency, redirects, stray acks.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(9, 0) < 7), ($urandom_range(15, 0) == 0), 8'($urandom),
           0, 3, ($urandom_range(7, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
